load_unit: RTL and testbench



---
 rtl/load_unit_pkg.sv | 36 +++
 rtl/load_extract.sv | 48 ++++
 rtl/load_unit.sv | 149 ++++++++++++++
 tb/tb_load_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared RV32I data-memory definitions.
// Holds the funct3 codes for loads and stores, the load FSM state
// encoding, and small helpers that classify a load request.
package load_unit_pkg;

  // Store funct3 codes (byte-enable path)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_LO = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_DONE   = 2'd3
  } load_state_e;

  function automatic logic load_is_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // A load crosses a word boundary when its last byte lands in the next word.
  function automatic logic load_crosses(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3)) ||
           ((f3 == F3_LW) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational align-and-extend for loads.
// Ports:
//   lo_i     : word at the low (first) address
//   hi_i     : following word, only meaningful for crossing loads
//   offset_i : byte offset of the load within the low word
//   funct3_i : load type
//   data_o   : aligned, sign/zero-extended result (0 for illegal funct3)
module load_extract
  import load_unit_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;

  assign shamt   = {offset_i, 3'b000};
  assign shifted = {hi_i, lo_i} >> shamt;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return 32'(s);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return 32'(s);
  endfunction

  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_LB:   data_o = sext8(shifted[7:0]);
      F3_LH:   data_o = sext16(shifted[15:0]);
      F3_LW:   data_o = shifted[31:0];
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RV32I load sequencer.
// Issues one or two word reads to data memory, aligns and extends the
// addressed bytes, and reports the result with a one-cycle valid pulse.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i, funct3_i,
//   addr_i                : load request (taken only while idle)
//   busy_o                : high while a memory read is outstanding
//   mem_req_o, mem_addr_o : word-aligned read request, held until ack
//   mem_ack_i, mem_rdata_i: read response
//   data_o, valid_o, err_o: load result, valid pulse, error flag
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic              err_o
);

  load_state_e       state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              cross_q;
  logic [31:0]       lo_buf_q;
  logic [31:0]       hi_buf_q;
  logic              busy_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              valid_q;
  logic              err_q;

  logic              cross_d;
  logic              reject_d;
  logic [31:0]       lo_d;
  logic [31:0]       hi_d;
  logic [31:0]       ext_d;

  assign cross_d  = load_crosses(funct3_i, addr_i[1:0]);
  assign reject_d = !load_is_legal(funct3_i) || (cross_d && !SPLIT_EN);

  // The word being acknowledged feeds the extractor directly so the result
  // can be registered on the same edge that enters DONE.
  assign lo_d = (state_q == ST_REQ_LO) ? mem_rdata_i : lo_buf_q;
  assign hi_d = (state_q == ST_REQ_HI) ? mem_rdata_i : hi_buf_q;

  load_extract u_extract (
    .lo_i     (lo_d),
    .hi_i     (hi_d),
    .offset_i (off_q),
    .funct3_i (funct3_q),
    .data_o   (ext_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      cross_q  <= 1'b0;
      lo_buf_q <= 32'h0;
      hi_buf_q <= 32'h0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= 32'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            funct3_q <= funct3_i;
            off_q    <= addr_i[1:0];
            cross_q  <= cross_d;
            if (reject_d) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              data_q  <= 32'h0;
            end else begin
              state_q <= ST_REQ_LO;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_REQ_LO: begin
          if (mem_ack_i) begin
            lo_buf_q <= mem_rdata_i;
            if (cross_q) begin
              state_q <= ST_REQ_HI;
              addr_q  <= addr_q + ADDR_W'(4);
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              req_q   <= 1'b0;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
              data_q  <= ext_d;
            end
          end
        end
        ST_REQ_HI: begin
          if (mem_ack_i) begin
            hi_buf_q <= mem_rdata_i;
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            err_q    <= 1'b0;
            data_q   <= ext_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        busy, req, valid, err;
  logic [31:0] maddr, data;

  logic        s_start;
  logic [2:0]  s_funct3;
  logic [31:0] s_addr;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic        n_busy, n_req, n_valid, n_err;
  logic [31:0] n_maddr, n_data;

  int checks = 0;
  int errors = 0;

  load_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3), .addr_i(addr),
    .busy_o(busy), .mem_req_o(req), .mem_addr_o(maddr), .mem_ack_i(ack),
    .mem_rdata_i(rdata), .data_o(data), .valid_o(valid), .err_o(err)
  );

  load_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_nosplit (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .funct3_i(s_funct3), .addr_i(s_addr),
    .busy_o(n_busy), .mem_req_o(n_req), .mem_addr_o(n_maddr), .mem_ack_i(s_ack),
    .mem_rdata_i(s_rdata), .data_o(n_data), .valid_o(n_valid), .err_o(n_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one load on the SPLIT_EN=1 unit with a simple memory model that
  // acks each request after dly wait cycles. poke_cyc>0 pulses a stray start.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] lo_w, input logic [31:0] hi_w,
                         input int dly, input int poke_cyc,
                         output logic [31:0] o_data, output logic o_err,
                         output int o_lat, output int o_nreq,
                         output logic [31:0] o_a0, output logic [31:0] o_a1,
                         output int o_vcnt);
    int wcnt;
    int post;
    o_data = 32'hxxxxxxxx; o_err = 1'bx; o_lat = -1; o_nreq = 0;
    o_a0 = 32'h5A5A5A5A; o_a1 = 32'h5A5A5A5A; o_vcnt = 0;
    wcnt = 0; post = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; addr = a; ack = 1'b0;
    for (int cyc = 1; cyc <= 60 && post < 3; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        funct3 = F3_LB; addr = 32'h0000_0200;
      end
      if (valid) begin
        if (o_lat < 0) begin
          o_lat = cyc; o_data = data; o_err = err;
        end
        o_vcnt++;
      end
      if (o_lat >= 0) post++;
      if (req) begin
        if (wcnt == dly) begin
          ack   = 1'b1;
          rdata = (maddr == {a[31:2], 2'b00}) ? lo_w : hi_w;
          if (o_nreq == 0) o_a0 = maddr; else o_a1 = maddr;
          o_nreq++;
          wcnt = 0;
        end else begin
          ack = 1'b0;
          wcnt++;
        end
      end else begin
        ack = 1'b0;
      end
    end
    ack = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req !== 1'b0)   begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL reset_maddr: got %h want 0", maddr); end
    checks++; if (n_req !== 1'b0 || n_valid !== 1'b0) begin errors++; $display("FAIL reset_nosplit: req %b valid %b want 0 0", n_req, n_valid); end
    rst = 1'b0;
  endtask

  task automatic test_lw_aligned();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    do_load(F3_LW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, d, e, lat, nr, a0, a1, vc);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++; if (nr !== 1) begin errors++; $display("FAIL lw_nreq: got %0d want 1", nr); end
    checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", a0); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL lw_pulses: got %0d want 1", vc); end
  endtask

  task automatic test_byte_half();
    logic [2:0]  f3s [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    for (int i = 0; i < 4; i++) begin
      do_load(f3s[i], ads[i], 32'h80FF7F01, 32'h0, 0, 0, d, e, lat, nr, a0, a1, vc);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL bh_data[%0d]: got %h want %h", i, d, exp[i]); end
      checks++; if (e !== 1'b0 || lat !== 2) begin errors++; $display("FAIL bh_err_lat[%0d]: got err %b lat %0d want 0 2", i, e, lat); end
    end
  endtask

  task automatic test_split();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    do_load(F3_LW, 32'h102, 32'h44332211, 32'h88776655, 2, 0, d, e, lat, nr, a0, a1, vc);
    checks++; if (d !== 32'h66554433) begin errors++; $display("FAIL split_data: got %h want 66554433", d); end
    checks++; if (a0 !== 32'h100 || a1 !== 32'h104) begin errors++; $display("FAIL split_addrs: got %h %h want 00000100 00000104", a0, a1); end
    checks++; if (nr !== 2) begin errors++; $display("FAIL split_nreq: got %0d want 2", nr); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL split_latency: got %0d want 7", lat); end
    checks++; if (vc !== 1 || e !== 1'b0) begin errors++; $display("FAIL split_pulse: got pulses %0d err %b want 1 0", vc, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    do_load(F3_LH, 32'hFFFFFFFF, 32'h11223344, 32'h000000AA, 0, 0, d, e, lat, nr, a0, a1, vc);
    checks++; if (d !== 32'hFFFFAA11) begin errors++; $display("FAIL wrap_data: got %h want ffffaa11", d); end
    checks++; if (a0 !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", a0); end
    checks++; if (a1 !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", a1); end
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL wrap_lat_err: got %0d %b want 3 0", lat, e); end
  endtask

  task automatic test_nosplit();
    logic [31:0] ads [2] = '{32'hFFFFFFFF, 32'h102};
    logic [2:0]  f3s [2] = '{F3_LH, F3_LW};
    logic saw_req;
    for (int i = 0; i < 2; i++) begin
      saw_req = 1'b0;
      @(negedge clk);
      s_start = 1'b1; s_funct3 = f3s[i]; s_addr = ads[i];
      @(negedge clk);
      s_start = 1'b0;
      saw_req = saw_req | n_req;
      checks++; if (n_valid !== 1'b1 || n_err !== 1'b1) begin errors++; $display("FAIL nosplit_valid_err[%0d]: got %b %b want 1 1", i, n_valid, n_err); end
      checks++; if (n_data !== 32'h0) begin errors++; $display("FAIL nosplit_data[%0d]: got %h want 0", i, n_data); end
      @(negedge clk);
      saw_req = saw_req | n_req;
      checks++; if (n_valid !== 1'b0 || n_err !== 1'b1) begin errors++; $display("FAIL nosplit_pulse_hold[%0d]: got valid %b err %b want 0 1", i, n_valid, n_err); end
      checks++; if (saw_req !== 1'b0 || n_busy !== 1'b0) begin errors++; $display("FAIL nosplit_noreq[%0d]: got req %b busy %b want 0 0", i, saw_req, n_busy); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    do_load(3'b011, 32'h100, 32'h12345678, 32'h0, 0, 0, d, e, lat, nr, a0, a1, vc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", e); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL illegal_noreq: got %0d want 0", nr); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL illegal_data: got %h want 0", d); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    do_load(F3_LW, 32'h100, 32'hA5A55A5A, 32'h0, 2, 2, d, e, lat, nr, a0, a1, vc);
    checks++; if (d !== 32'hA5A55A5A || e !== 1'b0) begin errors++; $display("FAIL ignore_data: got %h err %b want a5a55a5a 0", d, e); end
    checks++; if (vc !== 1 || nr !== 1) begin errors++; $display("FAIL ignore_count: got pulses %0d reqs %0d want 1 1", vc, nr); end
    checks++; if (busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy %b req %b want 0 0", busy, req); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, a0, a1; logic e; int lat, nr, vc;
    @(negedge clk);
    start = 1'b1; funct3 = F3_LW; addr = 32'h102;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b1; rdata = 32'h44332211;
    @(negedge clk);
    checks++; if (req !== 1'b1 || maddr !== 32'h104) begin errors++; $display("FAIL rmid_in_hi: got req %b addr %h want 1 00000104", req, maddr); end
    ack = 1'b1; rdata = 32'h88776655; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ack = 1'b0;
    checks++; if (busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy %b req %b want 0 0", busy, req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", valid); end
    checks++; if (data !== 32'h0 || maddr !== 32'h0) begin errors++; $display("FAIL rmid_data: got data %h addr %h want 0 0", data, maddr); end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after: got valid %b busy %b want 0 0", valid, busy); end
    do_load(F3_LW, 32'h100, 32'h0BADF00D, 32'h0, 0, 0, d, e, lat, nr, a0, a1, vc);
    checks++; if (d !== 32'h0BADF00D || lat !== 2) begin errors++; $display("FAIL rmid_recover: got %h lat %0d want 0badf00d 2", d, lat); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; funct3 = F3_LW; addr = 32'h100;
    @(negedge clk);
    start = 1'b0; ack = 1'b1; rdata = 32'h01020304;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || data !== 32'h01020304) begin errors++; $display("FAIL b2b_first: got valid %b data %h want 1 01020304", valid, data); end
    @(negedge clk);
    start = 1'b1; funct3 = F3_LBU; addr = 32'h101;
    @(negedge clk);
    start = 1'b0;
    checks++; if (req !== 1'b1 || maddr !== 32'h100) begin errors++; $display("FAIL b2b_accept: got req %b addr %h want 1 00000100", req, maddr); end
    ack = 1'b1; rdata = 32'hCAFEBABE;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || data !== 32'h000000BA) begin errors++; $display("FAIL b2b_second: got valid %b data %h want 1 000000ba", valid, data); end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || data !== 32'h000000BA) begin errors++; $display("FAIL b2b_hold: got valid %b data %h want 0 000000ba", valid, data); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; addr = 32'h0; ack = 1'b0; rdata = 32'h0;
    s_start = 1'b0; s_funct3 = 3'b000; s_addr = 32'h0; s_ack = 1'b0; s_rdata = 32'h0;
    test_reset();
    test_lw_aligned();
    test_byte_half();
    test_split();
    test_wrap();
    test_nosplit();
    test_illegal();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
